reg_if_id_skid: RTL and testbench
=================================

REG_IF_ID_SKID -- requirements
Module: reg_if_id_skid

Interface
Parameters:
REQ-001 SHALL have parameter ADDR_W, default 32, PC width.
REQ-002 SHALL have parameter INST_W, default 32, instruction width.
REQ-003 SHALL have parameter NOP_INST, default 32'h00000013, bubble instruction (addi x0,x0,0).
Ports:
REQ-004 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have if_valid  input  1  IF offers an instruction.
REQ-007 SHALL have if_ready  output  1  stage can accept; equals NOT skid_valid, purely from registers.
REQ-008 SHALL have if_pc  input  ADDR_W  fetched PC.
REQ-009 SHALL have if_inst  input  INST_W  fetched instruction.
REQ-010 SHALL have flush  input  1  branch/jump redirect; kills all held entries.
REQ-011 SHALL have id_valid  output  1  id_pc/id_inst hold a live instruction.
REQ-012 SHALL have id_ready  input  1  ID consumes the current entry.
REQ-013 SHALL have id_pc  output  ADDR_W  registered PC to ID.
REQ-014 SHALL have id_inst  output  INST_W  registered instruction to ID; NOP_INST whenever id_valid=0.

Function
REQ-015 SHALL define accept = if_valid & if_ready and drain = id_valid & id_ready.
REQ-016 SHALL hold two slots: main (drives id_*) and skid; states EMPTY (none valid), ONE (main valid), FULL (both valid).
REQ-017 SHALL in EMPTY: on accept load main, go ONE; else stay.
REQ-018 SHALL in ONE: accept & drain -> load main, stay ONE; accept & !drain -> load skid, go FULL; !accept & drain -> go EMPTY, id_inst<=NOP_INST, id_pc holds; neither -> hold.
REQ-019 SHALL in FULL: if_ready=0, so accept is impossible; drain -> main<=skid, go ONE; else hold all.
REQ-020 SHALL give 1-cycle latency from accept to id_valid when EMPTY or when draining in ONE, and sustain one instruction per cycle with id_ready held 1.
REQ-021 SHALL never drop, duplicate or reorder accepted instructions; order is program order.
REQ-022 SHALL keep id_pc/id_inst stable while id_valid=1 and id_ready=0.
REQ-023 SHALL on flush go EMPTY next edge: id_valid=0, id_inst=NOP_INST, skid cleared, if_ready=1; flush wins over simultaneous accept and drain (accepted word discarded).
REQ-024 SHALL ignore if_pc/if_inst when accept=0.

Reset
REQ-025 SHALL on rst asserted, immediately and independent of clk: id_valid=0, id_pc=0, id_inst=NOP_INST, skid cleared, state EMPTY, if_ready=1.
REQ-026 SHALL on rst asserted mid-operation discard all held instructions; first accept after deassert behaves as from EMPTY.

Structure
REQ-027 SHALL take NOP_INST default value, InstAddrBus/InstBus widths and the state encoding (EMPTY/ONE/FULL) from the shared defines file.
REQ-028 SHALL be a single module; no sub-module is needed (two slot registers plus 2-bit state).

Verification
REQ-029 SHALL test streaming: id_ready=1, IF offers pc 0x0,0x4,0x8 back-to-back -> id_pc 0x0,0x4,0x8 on the next three cycles, id_valid=1 throughout, if_ready=1 throughout.
REQ-030 SHALL test backpressure: id_ready=0, offer 0x10 then 0x14 -> if_ready=0 after second accept, 0x18 held off; raise id_ready -> outputs 0x10,0x14,0x18 in order, nothing lost.
REQ-031 SHALL test flush in FULL: slots hold 0x20,0x24, flush=1 with if_valid=1 pc 0x28 -> next cycle id_valid=0, id_inst=0x00000013, if_ready=1; 0x28 never appears.
REQ-032 SHALL test drain to empty: ONE state, id_ready=1, if_valid=0 -> id_valid=0, id_inst=0x00000013, id_pc unchanged.
REQ-033 SHALL test async reset: assert rst between edges while FULL -> outputs reset values before next clk edge; after deassert, offer 0x100 -> id_pc=0x100 one cycle later.
REQ-034 SHALL test parameters: ADDR_W=64, INST_W=16 instance passes scenario REQ-030 with pc 0x1_0000_0000.

Source files
------------

// File: rtl/reg_if_id_skid_pkg.sv
// Shared IF/ID pipeline definitions: bus widths, bubble instruction and the
// stage state encoding.
package reg_if_id_skid_pkg;

  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned INST_BUS_W      = 32;

  // addi x0,x0,0
  localparam logic [INST_BUS_W-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/reg_if_id_skid_if.sv
// IF -> ID handshake bundle; master is the fetch/decode environment, slave is
// the pipeline register.
interface reg_if_id_skid_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;

  modport master (
    output if_valid, if_pc, if_inst, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_inst
  );

  modport slave (
    input  if_valid, if_pc, if_inst, flush, id_ready,
    output if_ready, id_valid, id_pc, id_inst
  );
endinterface

// File: rtl/reg_if_id_skid.sv
// IF/ID pipeline register with a one-entry skid slot so IF can keep streaming
// for one cycle after ID stalls; flush turns the stage into a bubble.
module reg_if_id_skid
  import reg_if_id_skid_pkg::*;
#(
  parameter int unsigned           ADDR_W   = INST_ADDR_BUS_W,
  parameter int unsigned           INST_W   = INST_BUS_W,
  parameter logic [INST_BUS_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  reg_if_id_skid_if.slave    bus
);

  localparam logic [INST_W-1:0] NOP_W = INST_W'(NOP_INST);

  skid_state_e       state_q, state_d;
  logic [ADDR_W-1:0] main_pc_q, main_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic              id_valid_q, id_valid_d;
  logic              if_ready_q, if_ready_d;
  logic              accept, drain;

  assign accept = bus.if_valid & if_ready_q;
  assign drain  = id_valid_q & bus.id_ready;

  // State and slot registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_pc_q   <= '0;
      main_inst_q <= NOP_W;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_W;
      id_valid_q  <= 1'b0;
      if_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      id_valid_q  <= id_valid_d;
      if_ready_q  <= if_ready_d;
    end
  end

  // Next-state: flush overrides any simultaneous accept or drain
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !drain)      state_d = ST_FULL;
          else if (!accept && drain) state_d = ST_EMPTY;
        end
        ST_FULL:  if (drain) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Slot datapath and registered handshake outputs
  always_comb begin
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if (bus.flush) begin
      main_inst_d = NOP_W;
      skid_pc_d   = '0;
      skid_inst_d = NOP_W;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_pc_d   = bus.if_pc;
            main_inst_d = bus.if_inst;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_pc_d   = bus.if_pc;
            main_inst_d = bus.if_inst;
          end else if (accept) begin
            skid_pc_d   = bus.if_pc;
            skid_inst_d = bus.if_inst;
          end else if (drain) begin
            // id_pc keeps the last value; only the instruction becomes a bubble
            main_inst_d = NOP_W;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
            skid_pc_d   = '0;
            skid_inst_d = NOP_W;
          end
        end
        default: begin
          main_inst_d = NOP_W;
        end
      endcase
    end
    id_valid_d = (state_d != ST_EMPTY);
    if_ready_d = (state_d != ST_FULL);
  end

  assign bus.if_ready = if_ready_q;
  assign bus.id_valid = id_valid_q;
  assign bus.id_pc    = main_pc_q;
  assign bus.id_inst  = main_inst_q;

endmodule

// File: tb/tb_reg_if_id_skid.sv
// Bench for reg_if_id_skid: per-cycle vector table plus an in-order scoreboard
// on the 32-bit instance, and hand sequences for async reset and a 64/16 instance.
module tb_reg_if_id_skid;

  localparam logic [31:0] NOP32 = 32'h0000_0013;
  localparam logic [15:0] NOP16 = 16'h0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_if_id_skid_if #(.ADDR_W(32), .INST_W(32)) bus_a ();
  reg_if_id_skid_if #(.ADDR_W(64), .INST_W(16)) bus_b ();

  reg_if_id_skid #(.ADDR_W(32), .INST_W(32)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  reg_if_id_skid #(.ADDR_W(64), .INST_W(16)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'hABCD_0001;
  endfunction

  function automatic logic [15:0] mk_inst16(input logic [63:0] pc);
    return pc[15:0] ^ 16'h7E01;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Scoreboard: words accepted into instance A must leave in the same order
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;
  sb_t sb[$];

  always @(negedge clk) begin
    if (rst || bus_a.flush) begin
      sb.delete();
    end else begin
      if (bus_a.id_valid && bus_a.id_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", 64'(bus_a.id_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_pc", 64'(bus_a.id_pc), 64'(e.pc));
          chk("sb_inst", 64'(bus_a.id_inst), 64'(e.inst));
        end
      end
      if (bus_a.if_valid && bus_a.if_ready)
        sb.push_back('{pc: bus_a.if_pc, inst: bus_a.if_inst});
    end
  end

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        rdy;
    logic        fl;
    logic        e_ifr;
    logic        e_idv;
    logic [31:0] e_pc;
  } vec_t;

  localparam int unsigned NV = 18;
  vec_t tbl [NV];

  task automatic drive_a(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    bus_a.if_valid = v;
    bus_a.if_pc    = pc;
    bus_a.if_inst  = mk_inst(pc);
    bus_a.id_ready = rdy;
    bus_a.flush    = fl;
  endtask

  task automatic step_b(input logic v, input logic [63:0] pc, input logic rdy,
                        input logic e_ifr, input logic e_idv, input logic [63:0] e_pc);
    bus_b.if_valid = v;
    bus_b.if_pc    = pc;
    bus_b.if_inst  = mk_inst16(pc);
    bus_b.id_ready = rdy;
    @(posedge clk);
    #1;
    chk("b_if_ready", 64'(bus_b.if_ready), 64'(e_ifr));
    chk("b_id_valid", 64'(bus_b.id_valid), 64'(e_idv));
    chk("b_id_pc", bus_b.id_pc, e_pc);
    chk("b_id_inst", 64'(bus_b.id_inst), e_idv ? 64'(mk_inst16(e_pc)) : 64'(NOP16));
  endtask

  localparam logic [63:0] BB = 64'h1_0000_0000;
  localparam logic [31:0] XX = 32'hDEAD_BEEF;

  initial begin
    // streaming, then drain to empty with garbage on if_pc
    tbl[0]  = '{1'b1, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00};
    tbl[1]  = '{1'b1, 32'h04, 1'b1, 1'b0, 1'b1, 1'b1, 32'h04};
    tbl[2]  = '{1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 1'b1, 32'h08};
    tbl[3]  = '{1'b0, XX,     1'b1, 1'b0, 1'b1, 1'b0, 32'h08};
    // backpressure fills skid, 0x18 held off until ID resumes
    tbl[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10};
    tbl[5]  = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10};
    tbl[6]  = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10};
    tbl[7]  = '{1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 1'b1, 32'h14};
    tbl[8]  = '{1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 1'b1, 32'h18};
    tbl[9]  = '{1'b0, XX,     1'b1, 1'b0, 1'b1, 1'b0, 32'h18};
    // flush while FULL with a word offered
    tbl[10] = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20};
    tbl[11] = '{1'b1, 32'h24, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20};
    tbl[12] = '{1'b1, 32'h28, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20};
    tbl[13] = '{1'b0, XX,     1'b1, 1'b0, 1'b1, 1'b0, 32'h20};
    // flush in ONE beats simultaneous accept and drain
    tbl[14] = '{1'b1, 32'h30, 1'b1, 1'b0, 1'b1, 1'b1, 32'h30};
    tbl[15] = '{1'b1, 32'h34, 1'b1, 1'b1, 1'b1, 1'b0, 32'h30};
    tbl[16] = '{1'b1, 32'h38, 1'b1, 1'b0, 1'b1, 1'b1, 32'h38};
    tbl[17] = '{1'b0, XX,     1'b1, 1'b0, 1'b1, 1'b0, 32'h38};

    drive_a(1'b0, 32'h0, 1'b0, 1'b0);
    bus_b.if_valid = 1'b0;
    bus_b.if_pc    = '0;
    bus_b.if_inst  = '0;
    bus_b.id_ready = 1'b0;
    bus_b.flush    = 1'b0;

    // reset takes effect before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_if_ready", 64'(bus_a.if_ready), 64'd1);
    chk("rst_id_valid", 64'(bus_a.id_valid), 64'd0);
    chk("rst_id_pc", 64'(bus_a.id_pc), 64'd0);
    chk("rst_id_inst", 64'(bus_a.id_inst), 64'(NOP32));
    chk("rst_b_id_inst", 64'(bus_b.id_inst), 64'(NOP16));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // 64-bit PC / 16-bit instruction instance under backpressure
    step_b(1'b1, BB,        1'b0, 1'b1, 1'b1, BB);
    step_b(1'b1, BB + 64'h4, 1'b0, 1'b0, 1'b1, BB);
    step_b(1'b1, BB + 64'h8, 1'b0, 1'b0, 1'b1, BB);
    step_b(1'b1, BB + 64'h8, 1'b1, 1'b1, 1'b1, BB + 64'h4);
    step_b(1'b1, BB + 64'h8, 1'b1, 1'b1, 1'b1, BB + 64'h8);
    step_b(1'b0, 64'h0,      1'b1, 1'b1, 1'b0, BB + 64'h8);

    for (int i = 0; i < int'(NV); i++) begin
      drive_a(tbl[i].v, tbl[i].pc, tbl[i].rdy, tbl[i].fl);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_if_ready", i), 64'(bus_a.if_ready), 64'(tbl[i].e_ifr));
      chk($sformatf("v%0d_id_valid", i), 64'(bus_a.id_valid), 64'(tbl[i].e_idv));
      chk($sformatf("v%0d_id_pc", i), 64'(bus_a.id_pc), 64'(tbl[i].e_pc));
      chk($sformatf("v%0d_id_inst", i), 64'(bus_a.id_inst),
          tbl[i].e_idv ? 64'(mk_inst(tbl[i].e_pc)) : 64'(NOP32));
    end

    // fill to FULL, then assert reset between edges
    drive_a(1'b1, 32'h40, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive_a(1'b1, 32'h44, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("full_if_ready", 64'(bus_a.if_ready), 64'd0);
    drive_a(1'b0, XX, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_if_ready", 64'(bus_a.if_ready), 64'd1);
    chk("arst_id_valid", 64'(bus_a.id_valid), 64'd0);
    chk("arst_id_pc", 64'(bus_a.id_pc), 64'd0);
    chk("arst_id_inst", 64'(bus_a.id_inst), 64'(NOP32));
    @(posedge clk);
    #1 rst = 1'b0;
    drive_a(1'b1, 32'h100, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_id_valid", 64'(bus_a.id_valid), 64'd1);
    chk("post_rst_id_pc", 64'(bus_a.id_pc), 64'h100);
    chk("post_rst_id_inst", 64'(bus_a.id_inst), 64'(mk_inst(32'h100)));
    drive_a(1'b0, XX, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("end_id_valid", 64'(bus_a.id_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("sb_leftover", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // safety bound so the run always terminates
  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
